// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } pipe_state_e;

  localparam int CNT_W_DEFAULT = 32;

  // Bit positions inside the 7-bit decode control word
  localparam int CTRL_IMM_SEL  = 6;
  localparam int CTRL_RD1      = 4;
  localparam int CTRL_RD2      = 3;
  localparam int CTRL_REGWRITE = 2;

endpackage

// File: rtl/pipe_ctrl_sequencer_perf_counter.sv
// Enabled free-running counter with synchronous clear; wraps at 2^W.
module perf_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear wins over enable so a reset edge always leaves the counter at zero
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// Central pipeline control: stall/flush/PC decode, RUN/DRAIN/HALTED
// sequencing, performance counters and a stall watchdog.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_RUN    | normal issue; hlt > jmp > eff_stall > sequential fetch
// ST_DRAIN  | HLT seen; front end flushed until EX/MEM/WB are empty
// ST_HALTED | machine stopped, counters frozen until rst
module pipe_ctrl_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int STALL_LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dep_stall,
  input  logic             rr_valid,
  input  logic             ex_valid,
  input  logic             m_valid,
  input  logic             wb_valid,
  input  logic             ex_is_jmp,
  input  logic             ex_is_halt,
  output logic             pc_we,
  output logic             pc_sel_jmp,
  output logic             if_id_stall,
  output logic             id_rr_stall,
  output logic             if_id_flush,
  output logic             id_rr_flush,
  output logic             rr_ex_flush,
  output logic             halted,
  output logic             deadlock,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int RUN_W = $clog2(STALL_LIMIT + 1);

  pipe_state_e      state_q, state_d;
  logic [RUN_W-1:0] run_cnt;
  logic             jmp, hlt, eff_stall;
  logic             flush_all, stall_hold;
  logic             active, stall_counted, jmp_counted;

  assign jmp       = ex_valid & ex_is_jmp;
  assign hlt       = ex_valid & ex_is_halt;
  assign eff_stall = dep_stall & (rr_valid | ex_valid | m_valid | wb_valid);

  assign if_id_flush = flush_all;
  assign id_rr_flush = flush_all;
  assign rr_ex_flush = flush_all;
  assign if_id_stall = stall_hold;
  assign id_rr_stall = stall_hold;
  assign state       = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and zero-latency control decode
  always_comb begin
    state_d       = state_q;
    pc_we         = 1'b0;
    pc_sel_jmp    = 1'b0;
    stall_hold    = 1'b0;
    flush_all     = 1'b0;
    halted        = 1'b0;
    active        = 1'b0;
    stall_counted = 1'b0;
    jmp_counted   = 1'b0;
    case (state_q)
      ST_RUN: begin
        active = 1'b1;
        if (hlt) begin
          // HLT itself moves on to EX/MEM; everything younger is squashed
          flush_all = 1'b1;
          state_d   = ST_DRAIN;
        end else if (jmp) begin
          pc_we       = 1'b1;
          pc_sel_jmp  = 1'b1;
          flush_all   = 1'b1;
          jmp_counted = 1'b1;
        end else if (eff_stall) begin
          stall_hold    = 1'b1;
          stall_counted = 1'b1;
        end else begin
          pc_we = 1'b1;
        end
      end
      ST_DRAIN: begin
        active    = 1'b1;
        flush_all = 1'b1;
        if (!ex_valid && !m_valid && !wb_valid) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        flush_all = 1'b1;
        halted    = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Stall watchdog: counts consecutive counted stalls, sticky deadlock flag
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt  <= '0;
      deadlock <= 1'b0;
    end else if (stall_counted) begin
      if (run_cnt != RUN_W'(STALL_LIMIT)) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
      if (run_cnt >= RUN_W'(STALL_LIMIT - 1)) begin
        deadlock <= 1'b1;
      end
    end else begin
      run_cnt <= '0;
    end
  end

  perf_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (active),
    .count (cycle_cnt)
  );

  perf_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (active & wb_valid),
    .count (retire_cnt)
  );

  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (stall_counted),
    .count (stall_cnt)
  );

  perf_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (jmp_counted),
    .count (flush_cnt)
  );

endmodule
